e203_tcm_srams: RTL and testbench
=================================

Name: e203_tcm_srams

Overview:
Holds the two tightly-coupled memory arrays of the E203 core: ITCM (64 KiB, 8192 x 64-bit) and DTCM (64 KiB, 16384 x 32-bit).
Each bank is a single-port synchronous RAM with byte-write masks, one-cycle read latency and power-control inputs.
Both banks sit on one clock domain.
It sits below the core's ITCM/DTCM controllers, which drive cs/we/addr/wem/din and consume dout.

Parameters:
ITCM_AW, 13, ITCM address width; depth 2^ITCM_AW words.
ITCM_DW, 64, ITCM data width.
ITCM_MW, 8, ITCM byte-mask width (ITCM_DW/8).
DTCM_AW, 14, DTCM address width; depth 2^DTCM_AW words.
DTCM_DW, 32, DTCM data width.
DTCM_MW, 4, DTCM byte-mask width (DTCM_DW/8).

Ports:
clk_tcm_ram  in  1  single clock for both banks; all state updates on rising edge.
rst_tcm  in  1  synchronous, active-high reset.
itcm_ram_sd / itcm_ram_ds / itcm_ram_ls  in  1 each  ITCM shutdown / deep-sleep / light-sleep.
itcm_ram_cs  in  1  ITCM chip select.
itcm_ram_we  in  1  ITCM write enable (1 = write, 0 = read).
itcm_ram_addr  in  ITCM_AW  ITCM word address.
itcm_ram_wem  in  ITCM_MW  ITCM byte write mask; bit i covers din[8i+7:8i].
itcm_ram_din  in  ITCM_DW  ITCM write data.
itcm_ram_dout  out  ITCM_DW  ITCM read data.
dtcm_ram_sd / dtcm_ram_ds / dtcm_ram_ls  in  1 each  DTCM power controls; same meaning as ITCM.
dtcm_ram_cs, dtcm_ram_we, dtcm_ram_addr[DTCM_AW], dtcm_ram_wem[DTCM_MW], dtcm_ram_din[DTCM_DW]  in  DTCM equivalents of the ITCM inputs.
dtcm_ram_dout  out  DTCM_DW  DTCM read data.
test_mode  in  1  DFT indicator; no functional effect.

Behaviour:
- Banks are fully independent; identical rules apply to each.
- Access enable: en = cs & ~sd & ~ds. ls has no functional effect.
- Write (en & we): at the clock edge, for every i with wem[i] = 1, mem[addr] byte i <= din byte i. Bytes with wem[i] = 0 are unchanged. wem = 0 means no change. A write does not change dout.
- Read (en & ~we): the cycle after the edge, dout = mem[addr]. Read latency is exactly 1 cycle; wem is ignored on reads.
- Idle (~en): dout holds its last value. The memory is unchanged.
- Read-after-write to the same address on consecutive cycles returns the new data.
- Back-to-back reads are allowed every cycle.
- Addresses are fully decoded over 0 .. 2^AW-1; there is no aliasing and no wrap.
- Reset: while rst_tcm = 1 at a clock edge:
  - itcm_ram_dout <= 0 and dtcm_ram_dout <= 0.
  - Any access presented in that cycle is ignored, including writes.
  - Memory contents are not cleared; they are preserved across reset.
- Reads of never-written locations return an undefined value.
- Reset asserted mid-stream: the next cycle's dout is 0, and the read address of the aborted read is discarded.

Optional Feature:
E203_TCM_DOUT_LIVE_EN
- Defined: each bank registers the read address on a read, and dout = mem[addr_r] combinationally. A later write to that address becomes visible on dout after its write edge, with no new read. Reset clears addr_r to 0, and dout must still read 0 until the first post-reset read (gate with a valid flag).
- Undefined (default): dout is a data register loaded only on reads, and later writes do not affect it.

Decomposition:
- Package e203_tcm_pkg: the six width/depth constants above and a localparam for the byte size (8).
- One parameterised sub-module, e203_tcm_ram_bank (AW, DW, MW): it contains the memory array, enable gating, byte-masked write, read path and reset of dout.
- The top level instantiates it twice (ITCM, DTCM) and leaves test_mode/ls unconnected internally.

Test Plan:
- Reset: hold rst_tcm = 1 for 2 cycles -> itcm_ram_dout = 0 and dtcm_ram_dout = 0. A write to ITCM addr 5 during reset is not stored (a later read is not the written value).
- Full-word ITCM: write addr 0x1FFF, din 0x0123456789ABCDEF, wem 0xFF; read next cycle -> dout = 0x0123456789ABCDEF one cycle after the read edge.
- Byte mask DTCM: write addr 0x10 with 0xAABBCCDD, wem 0xF; then write 0x11223344, wem 0x5; read -> dout = 0xAA22CC44.
- Gating: dtcm sd = 1 with cs = 1, we = 1 writing 0xFFFFFFFF to 0x10 -> data unchanged, and dout holds its previous value. Same check with ds = 1. ls = 1 still allows the access.
- Independence/boundary: in the same cycle, write ITCM addr 0 and read DTCM addr 0x3FFF (preloaded 0xDEADBEEF) -> dtcm_ram_dout = 0xDEADBEEF while itcm_ram_dout holds.
- Hold: read ITCM addr 3 (= X), then write addr 3 with Y and idle -> dout stays X by default. With E203_TCM_DOUT_LIVE_EN defined, dout becomes Y after the write edge.

Source files
------------

// File: rtl/e203_tcm_pkg.sv
// Shared geometry constants for the E203 ITCM/DTCM SRAM banks.
package e203_tcm_pkg;

    localparam int ITCM_AW = 13;
    localparam int ITCM_DW = 64;
    localparam int ITCM_MW = 8;
    localparam int DTCM_AW = 14;
    localparam int DTCM_DW = 32;
    localparam int DTCM_MW = 4;
    localparam int BYTE_W  = 8;

endpackage

// File: rtl/e203_tcm_ram_bank.sv
// Single-port synchronous RAM bank with byte write mask and one-cycle read latency.
// Optional macro E203_TCM_DOUT_LIVE_EN: dout tracks mem[last read address] combinationally.
module e203_tcm_ram_bank
    import e203_tcm_pkg::*;
#(
    parameter int AW = 13,
    parameter int DW = 64,
    parameter int MW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sd,
    input  logic          ds,
    input  logic          cs,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [MW-1:0] wem,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    logic en_p0;
    logic wr_p0;
    logic rd_p0;

    assign en_p0 = cs & ~sd & ~ds;
    // Accesses presented during reset are dropped, writes included.
    assign wr_p0 = en_p0 &  we & ~rst;
    assign rd_p0 = en_p0 & ~we;

    // Memory contents have no reset and survive rst.
    always_ff @(posedge clk) begin
        if (wr_p0) begin
            for (int i = 0; i < MW; i++) begin
                if (wem[i]) begin
                    mem[addr][i*BYTE_W +: BYTE_W] <= din[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // ---- p0 -> p1 : read stage ----
`ifdef E203_TCM_DOUT_LIVE_EN
    logic [AW-1:0] rd_addr_p1;
    logic          vld_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_p1 <= '0;
            vld_p1     <= 1'b0;
        end else if (rd_p0) begin
            rd_addr_p1 <= addr;
            vld_p1     <= 1'b1;
        end
    end

    assign dout = vld_p1 ? mem[rd_addr_p1] : '0;
`else
    logic [DW-1:0] dout_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_p1 <= '0;
        end else if (rd_p0) begin
            dout_p1 <= mem[addr];
        end
    end

    assign dout = dout_p1;
`endif

endmodule

// File: rtl/e203_tcm_srams.sv
// ITCM (8192x64) and DTCM (16384x32) SRAM banks on a shared clock.
// Optional macro E203_TCM_DOUT_LIVE_EN selects live read-data behaviour in both banks.
module e203_tcm_srams
    import e203_tcm_pkg::*;
(
    input  logic               clk_tcm_ram,
    input  logic               rst_tcm,
    input  logic               test_mode,

    input  logic               itcm_ram_sd,
    input  logic               itcm_ram_ds,
    input  logic               itcm_ram_ls,
    input  logic               itcm_ram_cs,
    input  logic               itcm_ram_we,
    input  logic [ITCM_AW-1:0] itcm_ram_addr,
    input  logic [ITCM_MW-1:0] itcm_ram_wem,
    input  logic [ITCM_DW-1:0] itcm_ram_din,
    output logic [ITCM_DW-1:0] itcm_ram_dout,

    input  logic               dtcm_ram_sd,
    input  logic               dtcm_ram_ds,
    input  logic               dtcm_ram_ls,
    input  logic               dtcm_ram_cs,
    input  logic               dtcm_ram_we,
    input  logic [DTCM_AW-1:0] dtcm_ram_addr,
    input  logic [DTCM_MW-1:0] dtcm_ram_wem,
    input  logic [DTCM_DW-1:0] dtcm_ram_din,
    output logic [DTCM_DW-1:0] dtcm_ram_dout
);

    // Light-sleep and DFT mode carry no functional meaning for the behavioural arrays.
    logic unused_ok;
    assign unused_ok = &{1'b0, test_mode, itcm_ram_ls, dtcm_ram_ls, 1'b0};

    e203_tcm_ram_bank #(
        .AW (ITCM_AW),
        .DW (ITCM_DW),
        .MW (ITCM_MW)
    ) u_itcm (
        .clk  (clk_tcm_ram),
        .rst  (rst_tcm),
        .sd   (itcm_ram_sd),
        .ds   (itcm_ram_ds),
        .cs   (itcm_ram_cs),
        .we   (itcm_ram_we),
        .addr (itcm_ram_addr),
        .wem  (itcm_ram_wem),
        .din  (itcm_ram_din),
        .dout (itcm_ram_dout)
    );

    e203_tcm_ram_bank #(
        .AW (DTCM_AW),
        .DW (DTCM_DW),
        .MW (DTCM_MW)
    ) u_dtcm (
        .clk  (clk_tcm_ram),
        .rst  (rst_tcm),
        .sd   (dtcm_ram_sd),
        .ds   (dtcm_ram_ds),
        .cs   (dtcm_ram_cs),
        .we   (dtcm_ram_we),
        .addr (dtcm_ram_addr),
        .wem  (dtcm_ram_wem),
        .din  (dtcm_ram_din),
        .dout (dtcm_ram_dout)
    );

endmodule

// File: tb/tb_e203_tcm_srams.sv
// Scoreboard bench for e203_tcm_srams: directed cases plus a random masked read/write run.
module tb_e203_tcm_srams;

    logic        clk_tcm_ram = 1'b0;
    logic        rst_tcm;
    logic        test_mode;
    logic        itcm_ram_sd, itcm_ram_ds, itcm_ram_ls, itcm_ram_cs, itcm_ram_we;
    logic [12:0] itcm_ram_addr;
    logic [7:0]  itcm_ram_wem;
    logic [63:0] itcm_ram_din;
    logic [63:0] itcm_ram_dout;
    logic        dtcm_ram_sd, dtcm_ram_ds, dtcm_ram_ls, dtcm_ram_cs, dtcm_ram_we;
    logic [13:0] dtcm_ram_addr;
    logic [3:0]  dtcm_ram_wem;
    logic [31:0] dtcm_ram_din;
    logic [31:0] dtcm_ram_dout;

    always #5 clk_tcm_ram = ~clk_tcm_ram;

    e203_tcm_srams dut (
        .clk_tcm_ram   (clk_tcm_ram),
        .rst_tcm       (rst_tcm),
        .test_mode     (test_mode),
        .itcm_ram_sd   (itcm_ram_sd),
        .itcm_ram_ds   (itcm_ram_ds),
        .itcm_ram_ls   (itcm_ram_ls),
        .itcm_ram_cs   (itcm_ram_cs),
        .itcm_ram_we   (itcm_ram_we),
        .itcm_ram_addr (itcm_ram_addr),
        .itcm_ram_wem  (itcm_ram_wem),
        .itcm_ram_din  (itcm_ram_din),
        .itcm_ram_dout (itcm_ram_dout),
        .dtcm_ram_sd   (dtcm_ram_sd),
        .dtcm_ram_ds   (dtcm_ram_ds),
        .dtcm_ram_ls   (dtcm_ram_ls),
        .dtcm_ram_cs   (dtcm_ram_cs),
        .dtcm_ram_we   (dtcm_ram_we),
        .dtcm_ram_addr (dtcm_ram_addr),
        .dtcm_ram_wem  (dtcm_ram_wem),
        .dtcm_ram_din  (dtcm_ram_din),
        .dtcm_ram_dout (dtcm_ram_dout)
    );

`ifdef E203_TCM_DOUT_LIVE_EN
    localparam bit LIVE = 1'b1;
`else
    localparam bit LIVE = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t qi[$];
    exp_t qd[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic exp_i(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        qi.push_back(e);
    endtask

    task automatic exp_d(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = {32'h0, v};
        qd.push_back(e);
    endtask

    // Advance one edge, then retire every expectation queued for it.
    task automatic tick();
        exp_t e;
        @(posedge clk_tcm_ram);
        #1;
        while (qi.size() > 0) begin
            e = qi.pop_front();
            check(e.tag, itcm_ram_dout, e.val);
        end
        while (qd.size() > 0) begin
            e = qd.pop_front();
            check(e.tag, {32'h0, dtcm_ram_dout}, e.val);
        end
    endtask

    task automatic drv_i(input logic cs, input logic we, input logic [12:0] a,
                         input logic [7:0] m, input logic [63:0] d);
        itcm_ram_cs   = cs;
        itcm_ram_we   = we;
        itcm_ram_addr = a;
        itcm_ram_wem  = m;
        itcm_ram_din  = d;
    endtask

    task automatic drv_d(input logic cs, input logic we, input logic [13:0] a,
                         input logic [3:0] m, input logic [31:0] d);
        dtcm_ram_cs   = cs;
        dtcm_ram_we   = we;
        dtcm_ram_addr = a;
        dtcm_ram_wem  = m;
        dtcm_ram_din  = d;
    endtask

    function automatic logic [63:0] apply_mask(input logic [63:0] old, input logic [63:0] din,
                                               input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) r[i*8 +: 8] = din[i*8 +: 8];
        end
        return r;
    endfunction

    logic [63:0] im [16];
    logic [31:0] dm [16];
    logic [63:0] cur_i;
    logic [31:0] cur_d;
    int          last_i, last_d;

    initial begin
        rst_tcm = 1'b1;
        test_mode = 1'b0;
        itcm_ram_sd = 0; itcm_ram_ds = 0; itcm_ram_ls = 0;
        dtcm_ram_sd = 0; dtcm_ram_ds = 0; dtcm_ram_ls = 0;
        drv_d(0, 0, 0, 0, 0);

        // Reset held two cycles with a write presented
        drv_i(1, 1, 13'd5, 8'hFF, 64'hBBBB_BBBB_BBBB_BBBB);
        for (int k = 0; k < 2; k++) begin
            exp_i("rst_i", 64'h0); exp_d("rst_d", 32'h0); tick();
        end
        rst_tcm = 1'b0;

        drv_i(1, 1, 13'd5, 8'hFF, 64'h1111_2222_3333_4444);
        exp_i("wr_no_dout", 64'h0); tick();
        drv_i(1, 0, 13'd5, 8'h00, 64'h0);
        exp_i("rd5", 64'h1111_2222_3333_4444); tick();

        // Reset mid-stream with a write and a read presented
        rst_tcm = 1'b1;
        drv_i(1, 1, 13'd5, 8'hFF, 64'hBBBB_BBBB_BBBB_BBBB);
        drv_d(1, 0, 14'd7, 4'h0, 32'h0);
        exp_i("mrst_i", 64'h0); exp_d("mrst_d", 32'h0); tick();
        rst_tcm = 1'b0;
        drv_i(0, 0, 0, 0, 0); drv_d(0, 0, 0, 0, 0);
        exp_i("post_rst_i", 64'h0); exp_d("post_rst_d", 32'h0); tick();
        drv_i(1, 0, 13'd5, 8'h00, 64'h0);
        exp_i("rst_wr_drop", 64'h1111_2222_3333_4444); tick();

        // Full word at the top ITCM address, then back-to-back reads
        drv_i(1, 1, 13'h1FFF, 8'hFF, 64'h0123_4567_89AB_CDEF);
        exp_i("wr_hold", 64'h1111_2222_3333_4444); tick();
        drv_i(1, 0, 13'h1FFF, 8'h00, 64'h0);
        exp_i("rd_1fff", 64'h0123_4567_89AB_CDEF); tick();
        drv_i(1, 0, 13'd5, 8'hFF, 64'h0);
        exp_i("b2b_a", 64'h1111_2222_3333_4444); tick();
        drv_i(1, 0, 13'h1FFF, 8'h00, 64'h0);
        exp_i("b2b_b", 64'h0123_4567_89AB_CDEF); tick();
        drv_i(0, 0, 0, 0, 0);

        // DTCM byte mask
        drv_d(1, 1, 14'h10, 4'hF, 32'hAABB_CCDD); tick();
        drv_d(1, 1, 14'h10, 4'h5, 32'h1122_3344); tick();
        drv_d(1, 0, 14'h10, 4'h0, 32'h0);
        exp_d("mask", 32'hAA22_CC44); tick();

        // Power gating
        dtcm_ram_sd = 1;
        drv_d(1, 1, 14'h10, 4'hF, 32'hFFFF_FFFF);
        exp_d("sd_wr", 32'hAA22_CC44); tick();
        dtcm_ram_sd = 0; dtcm_ram_ds = 1;
        exp_d("ds_wr", 32'hAA22_CC44); tick();
        dtcm_ram_ds = 0; dtcm_ram_sd = 1;
        drv_d(1, 0, 14'h3FFF, 4'h0, 32'h0);
        exp_d("sd_rd", 32'hAA22_CC44); tick();
        dtcm_ram_sd = 0;
        drv_d(1, 0, 14'h10, 4'h0, 32'h0);
        exp_d("gated_keep", 32'hAA22_CC44); tick();
        dtcm_ram_ls = 1;
        drv_d(1, 1, 14'h10, 4'hF, 32'h5566_7788);
        exp_d("ls_wr", LIVE ? 32'h5566_7788 : 32'hAA22_CC44); tick();
        drv_d(1, 0, 14'h10, 4'h0, 32'h0);
        exp_d("ls_rd", 32'h5566_7788); tick();
        dtcm_ram_ls = 0;

        // Bank independence at the top DTCM address
        drv_d(1, 1, 14'h3FFF, 4'hF, 32'hDEAD_BEEF);
        exp_d("pre_hold", 32'h5566_7788); tick();
        drv_i(1, 1, 13'd0, 8'hFF, 64'hCAFE_F00D_1234_5678);
        drv_d(1, 0, 14'h3FFF, 4'h0, 32'h0);
        exp_i("indep_i", 64'h0123_4567_89AB_CDEF);
        exp_d("indep_d", 32'hDEAD_BEEF); tick();
        drv_d(0, 0, 0, 0, 0);
        drv_i(1, 0, 13'd0, 8'h00, 64'h0);
        exp_i("rd0", 64'hCAFE_F00D_1234_5678); tick();

        // Hold after a later write to the read address
        drv_i(1, 1, 13'd3, 8'hFF, 64'h0000_0000_0000_00A5); tick();
        drv_i(1, 0, 13'd3, 8'h00, 64'h0);
        exp_i("rd3", 64'h0000_0000_0000_00A5); tick();
        drv_i(1, 1, 13'd3, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A);
        exp_i("hold_wr", LIVE ? 64'h5A5A_5A5A_5A5A_5A5A : 64'h0000_0000_0000_00A5); tick();
        drv_i(0, 0, 0, 0, 0);
        exp_i("hold_idle", LIVE ? 64'h5A5A_5A5A_5A5A_5A5A : 64'h0000_0000_0000_00A5); tick();

        // Random run over 16 preloaded words per bank
        for (int k = 0; k < 16; k++) begin
            im[k] = {$urandom, $urandom};
            dm[k] = $urandom;
            drv_i(1, 1, 13'(k), 8'hFF, im[k]);
            drv_d(1, 1, 14'(k), 4'hF, dm[k]);
            tick();
        end
        drv_i(1, 0, 13'd0, 8'h00, 64'h0);
        drv_d(1, 0, 14'd0, 4'h0, 32'h0);
        cur_i = im[0]; cur_d = dm[0]; last_i = 0; last_d = 0;
        exp_i("rnd_init_i", cur_i); exp_d("rnd_init_d", cur_d); tick();

        for (int n = 0; n < 300; n++) begin
            logic [3:0]  ai, ad;
            logic        en;
            logic [63:0] wd;
            ai = 4'($urandom); ad = 4'($urandom);
            wd = {$urandom, $urandom};
            drv_i($urandom_range(0, 3) != 0, 1'($urandom), {9'h0, ai}, 8'($urandom), wd);
            drv_d($urandom_range(0, 3) != 0, 1'($urandom), {10'h0, ad}, 4'($urandom), wd[31:0]);
            itcm_ram_sd = ($urandom_range(0, 9) == 0);
            itcm_ram_ds = ($urandom_range(0, 9) == 0);
            dtcm_ram_sd = ($urandom_range(0, 9) == 0);
            dtcm_ram_ds = ($urandom_range(0, 9) == 0);
            itcm_ram_ls = 1'($urandom);
            dtcm_ram_ls = 1'($urandom);

            en = itcm_ram_cs & ~itcm_ram_sd & ~itcm_ram_ds;
            if (en && itcm_ram_we) im[ai] = apply_mask(im[ai], wd, itcm_ram_wem);
            else if (en) begin cur_i = im[ai]; last_i = int'(ai); end
            exp_i("rnd_i", LIVE ? im[last_i] : cur_i);

            en = dtcm_ram_cs & ~dtcm_ram_sd & ~dtcm_ram_ds;
            if (en && dtcm_ram_we)
                dm[ad] = 32'(apply_mask({32'h0, dm[ad]}, {32'h0, wd[31:0]}, {4'h0, dtcm_ram_wem}));
            else if (en) begin cur_d = dm[ad]; last_d = int'(ad); end
            exp_d("rnd_d", LIVE ? dm[last_d] : cur_d);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
